// File: rtl/spiker_reader_pkg.sv
// Shared constants and types for the spiker input-frame reader.
package spiker_reader_pkg;

  localparam int SPIKER_WIDTH    = 32;
  localparam int SPIKER_N_SPIKES = 784;
  localparam int SPIKER_STEP_W   = 16;
  localparam int SPIKER_N_REG    = (SPIKER_N_SPIKES + SPIKER_WIDTH - 1) / SPIKER_WIDTH;
  localparam int SPIKER_LAST_REM = SPIKER_N_SPIKES % SPIKER_WIDTH;

  // Valid-bit mask for the final frame word; bits past the last neuron are padding.
  localparam logic [SPIKER_WIDTH-1:0] SPIKER_LAST_MASK =
    (SPIKER_LAST_REM == 0) ? {SPIKER_WIDTH{1'b1}}
                           : ~({SPIKER_WIDTH{1'b1}} << SPIKER_LAST_REM);

  typedef enum logic [1:0] {
    READER_IDLE = 2'd0,
    READER_SEND = 2'd1,
    READER_DONE = 2'd2
  } reader_state_e;

endpackage

// File: rtl/spiker_reader_if.sv
// Valid/ready word stream from the spike reader to the spiking core.
interface spiker_reader_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
);
  logic [WIDTH-1:0] word;
  logic [IDX_W-1:0] wordIdx;
  logic             last;
  logic             valid;
  logic             ready;

  modport master (output word, wordIdx, last, valid, input ready);
  modport slave  (input word, wordIdx, last, valid, output ready);
endinterface

// File: rtl/spiker_popcount.sv
// Combinational population count of a single stream word.
module spiker_popcount #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         word_i,
  output logic [$clog2(WIDTH+1)-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int b = 0; b < WIDTH; b++) begin
      cnt_o = cnt_o + ($clog2(WIDTH+1))'(word_i[b]);
    end
  end

endmodule

// File: rtl/spiker_reader.sv
// Snapshots the software-written spike frame on start and replays it to the core
// once per timestep, counting active spikes on the first pass.
module spiker_reader
  import spiker_reader_pkg::*;
#(
  parameter int WIDTH    = SPIKER_WIDTH,
  parameter int N_SPIKES = SPIKER_N_SPIKES,
  parameter int STEP_W   = SPIKER_STEP_W,
  localparam int N_REG   = (N_SPIKES + WIDTH - 1) / WIDTH,
  localparam int IDX_W   = $clog2(N_REG),
  localparam int CNT_W   = $clog2(N_SPIKES + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REG*WIDTH-1:0] spikes_i,
  input  logic                   start_i,
  input  logic [STEP_W-1:0]      n_steps_i,
  spiker_reader_if.master        stream,
  output logic [STEP_W-1:0]      step_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CNT_W-1:0]       spike_cnt_o
);

  localparam int               LAST_REM  = N_SPIKES % WIDTH;
  localparam logic [WIDTH-1:0] LAST_MASK = (LAST_REM == 0) ? {WIDTH{1'b1}}
                                                           : ~({WIDTH{1'b1}} << LAST_REM);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REG - 1);
  localparam int               POP_W     = $clog2(WIDTH + 1);

  reader_state_e     state_q;
  logic [WIDTH-1:0]  frame_q [N_REG];
  logic [WIDTH-1:0]  snap_d  [N_REG];
  logic [IDX_W-1:0]  wordIdx_q;
  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] nSteps_q;
  logic [CNT_W-1:0]  spikeCnt_q;
  logic [CNT_W-1:0]  spikeCnt_d;
  logic [POP_W-1:0]  wordPop;
  logic [WIDTH-1:0]  curWord;
  logic              sending;
  logic              atLastWord;

  // Padding bits of the final register are dropped before they can reach the core.
  always_comb begin
    for (int i = 0; i < N_REG; i++) begin
      snap_d[i] = spikes_i[i*WIDTH +: WIDTH];
    end
    snap_d[N_REG-1] = spikes_i[(N_REG-1)*WIDTH +: WIDTH] & LAST_MASK;
  end

  assign sending    = (state_q == READER_SEND);
  assign atLastWord = (wordIdx_q == LAST_IDX);
  assign curWord    = frame_q[wordIdx_q] & (atLastWord ? LAST_MASK : {WIDTH{1'b1}});

  assign stream.word    = curWord;
  assign stream.wordIdx = wordIdx_q;
  assign stream.last    = sending && atLastWord;
  assign stream.valid   = sending;

  assign step_o      = step_q;
  assign busy_o      = sending;
  assign done_o      = (state_q == READER_DONE);
  assign spike_cnt_o = spikeCnt_q;

  spiker_popcount #(.WIDTH(WIDTH)) u_popcount (
    .word_i (curWord),
    .cnt_o  (wordPop)
  );

  assign spikeCnt_d = spikeCnt_q + CNT_W'(wordPop);

  // Step end compares against the latched count so a wrapping step counter is harmless.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= READER_IDLE;
      wordIdx_q  <= '0;
      step_q     <= '0;
      nSteps_q   <= '0;
      spikeCnt_q <= '0;
      for (int i = 0; i < N_REG; i++) begin
        frame_q[i] <= '0;
      end
    end else begin
      case (state_q)
        READER_IDLE: begin
          if (start_i) begin
            wordIdx_q  <= '0;
            step_q     <= '0;
            spikeCnt_q <= '0;
            if (n_steps_i != '0) begin
              frame_q  <= snap_d;
              nSteps_q <= n_steps_i;
              state_q  <= READER_SEND;
            end else begin
              state_q  <= READER_DONE;
            end
          end
        end
        READER_SEND: begin
          if (stream.ready) begin
            if (step_q == '0) begin
              spikeCnt_q <= spikeCnt_d;
            end
            if (atLastWord) begin
              wordIdx_q <= '0;
              step_q    <= step_q + STEP_W'(1);
              if (step_q == nSteps_q - STEP_W'(1)) begin
                state_q <= READER_DONE;
              end
            end else begin
              wordIdx_q <= wordIdx_q + IDX_W'(1);
            end
          end
        end
        READER_DONE: begin
          state_q <= READER_IDLE;
        end
        default: begin
          state_q <= READER_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spiker_reader.sv
// Randomized self-checking bench for spiker_reader against a frame-level reference model.
module tb_spiker_reader;
  import spiker_reader_pkg::*;

  localparam int WIDTH    = 32;
  localparam int N_SPIKES = 784;
  localparam int STEP_W   = 16;
  localparam int N_REG    = 25;
  localparam int IDX_W    = 5;
  localparam int CNT_W    = 10;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [STEP_W-1:0]      nSteps;
  logic [N_REG*WIDTH-1:0] spikes;
  logic [STEP_W-1:0]      step;
  logic                   busy;
  logic                   done;
  logic [CNT_W-1:0]       spikeCnt;

  spiker_reader_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) stream ();

  spiker_reader #(.WIDTH(WIDTH), .N_SPIKES(N_SPIKES), .STEP_W(STEP_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .spikes_i    (spikes),
    .start_i     (start),
    .n_steps_i   (nSteps),
    .stream      (stream),
    .step_o      (step),
    .busy_o      (busy),
    .done_o      (done),
    .spike_cnt_o (spikeCnt)
  );

  always #5 clk = ~clk;

  int               testsRun = 0;
  int               testsFailed = 0;
  logic [WIDTH-1:0] expFrame [N_REG];
  int               expCnt;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: neuron n lives at bit n of the packed frame; neurons past N_SPIKES do not exist.
  task automatic buildModel();
    expCnt = 0;
    for (int i = 0; i < N_REG; i++) begin
      for (int b = 0; b < WIDTH; b++) begin
        expFrame[i][b] = (i*WIDTH + b < N_SPIKES) ? spikes[i*WIDTH + b] : 1'b0;
        if (expFrame[i][b]) expCnt++;
      end
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_valid"}, stream.valid, 0);
    checkOutput({tag, "_last"}, stream.last, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_word"}, stream.word, 0);
    checkOutput({tag, "_idx"}, stream.wordIdx, 0);
    checkOutput({tag, "_step"}, step, 0);
    checkOutput({tag, "_cnt"}, spikeCnt, 0);
  endtask

  task automatic applyStimulus(input int steps, input int readyPct, input bit disturb,
                               input int abortStep, input int abortWord);
    int total;
    int xfers;
    int edges;
    bit r;
    buildModel();
    start  = 1'b1;
    nSteps = STEP_W'(steps);
    tick();
    start = 1'b0;
    edges = 1;
    if (steps == 0) begin
      checkOutput("zero_done", done, 1);
      checkOutput("zero_valid", stream.valid, 0);
      checkOutput("zero_cnt", spikeCnt, 0);
      tick();
      checkOutput("zero_done_pulse", done, 0);
      checkOutput("zero_valid_after", stream.valid, 0);
      return;
    end
    total = N_REG * steps;
    xfers = 0;
    while (xfers < total) begin
      if (edges > total*20 + 100) begin
        checkOutput("timeout", 1, 0);
        return;
      end
      checkOutput("valid", stream.valid, 1);
      checkOutput("busy", busy, 1);
      checkOutput("done_early", done, 0);
      checkOutput("word_idx", stream.wordIdx, xfers % N_REG);
      checkOutput("word", stream.word, expFrame[xfers % N_REG]);
      checkOutput("last", stream.last, (xfers % N_REG) == N_REG - 1);
      checkOutput("step", step, xfers / N_REG);
      if (abortStep == xfers / N_REG && abortWord == xfers % N_REG) begin
        rst = 1'b1;
        stream.ready = 1'($urandom_range(0, 1));
        tick();
        rst = 1'b0;
        stream.ready = 1'b0;
        checkResetValues("abort");
        tick();
        checkOutput("abort_no_done", done, 0);
        checkOutput("abort_valid_low", stream.valid, 0);
        return;
      end
      r = ($urandom_range(0, 99) < readyPct);
      stream.ready = r;
      if (disturb && xfers == 30) begin
        start  = 1'b1;
        nSteps = STEP_W'($urandom_range(1, 9));
        for (int i = 0; i < N_REG; i++) spikes[i*WIDTH +: WIDTH] = $urandom;
      end else begin
        start = 1'b0;
      end
      tick();
      edges++;
      if (r) xfers++;
    end
    start = 1'b0;
    stream.ready = 1'($urandom_range(0, 1));
    checkOutput("done", done, 1);
    checkOutput("busy_end", busy, 0);
    checkOutput("valid_end", stream.valid, 0);
    checkOutput("spike_cnt", spikeCnt, expCnt);
    if (readyPct == 100) checkOutput("done_latency", edges, total + 1);
    tick();
    checkOutput("done_pulse", done, 0);
    checkOutput("cnt_hold", spikeCnt, expCnt);
    checkOutput("valid_idle", stream.valid, 0);
    stream.ready = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    nSteps       = '0;
    stream.ready = 1'b0;
    for (int i = 0; i < N_REG; i++) spikes[i*WIDTH +: WIDTH] = $urandom;
    tick();
    tick();
    rst = 1'b0;
    checkResetValues("reset");

    spikes = '1;
    applyStimulus(1, 100, 1'b0, -1, -1);
    checkOutput("cnt_all_ones", spikeCnt, N_SPIKES);

    for (int i = 0; i < N_REG; i++) spikes[i*WIDTH +: WIDTH] = WIDTH'(i);
    applyStimulus(3, 100, 1'b0, -1, -1);

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N_REG; i++) spikes[i*WIDTH +: WIDTH] = $urandom;
      applyStimulus($urandom_range(1, 3), 50, 1'b0, -1, -1);
    end

    for (int i = 0; i < N_REG; i++) spikes[i*WIDTH +: WIDTH] = $urandom;
    applyStimulus(0, 100, 1'b0, -1, -1);

    for (int i = 0; i < N_REG; i++) spikes[i*WIDTH +: WIDTH] = $urandom;
    applyStimulus(2, 70, 1'b1, -1, -1);

    for (int i = 0; i < N_REG; i++) spikes[i*WIDTH +: WIDTH] = $urandom;
    applyStimulus(3, 100, 1'b0, 1, 10);

    for (int i = 0; i < N_REG; i++) spikes[i*WIDTH +: WIDTH] = $urandom;
    applyStimulus(2, 100, 1'b0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
